// File: rtl/mode_counter_if.sv
// Control/status bundle for mode_counter: the driver owns the controls,
// the counter owns the count and flags.
interface mode_counter_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             at_max;
  logic             at_zero;

  modport master (
    output en, load, load_val, limit, mode,
    input  count, wrap, at_max, at_zero
  );

  modport slave (
    input  en, load, load_val, limit, mode,
    output count, wrap, at_max, at_zero
  );
endinterface

// File: rtl/mode_counter.sv
// Prescaled 0..limit counter with up-wrap, down-wrap, up-saturate and ping-pong modes,
// a registered wrap pulse and combinational at_max/at_zero flags.
module mode_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input logic           clk,
  input logic           reset,
  mode_counter_if.slave bus
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0]   PsMax = PsW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] One   = WIDTH'(1);

  typedef enum logic {DirDown = 1'b0, DirUp = 1'b1} dir_e;

  logic [WIDTH-1:0] count_q, count_d;
  logic [PsW-1:0]   ps_q, ps_d;
  dir_e             dir_q, dir_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    ps_d    = ps_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      count_d = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      ps_d    = '0;
    end else if (bus.en) begin
      if (ps_q != PsMax) begin
        ps_d = ps_q + PsW'(1);
      end else begin
        ps_d = '0;
        case (bus.mode)
          2'b00: begin
            if (count_q < bus.limit) begin
              count_d = count_q + One;
            end else begin
              count_d = '0;
              wrap_d  = 1'b1;
            end
          end
          2'b01: begin
            if (count_q != '0) begin
              count_d = count_q - One;
            end else begin
              count_d = bus.limit;
              wrap_d  = 1'b1;
            end
          end
          2'b10: begin
            count_d = (count_q < bus.limit) ? count_q + One : bus.limit;
          end
          2'b11: begin
            // A zero-length range has nowhere to bounce: pin to 0 and keep direction.
            if (bus.limit == '0) begin
              count_d = '0;
            end else if (dir_q == DirUp) begin
              if (count_q < bus.limit) begin
                count_d = count_q + One;
              end else begin
                count_d = bus.limit - One;
                dir_d   = DirDown;
                wrap_d  = 1'b1;
              end
            end else if (count_q != '0) begin
              count_d = count_q - One;
            end else begin
              count_d = One;
              dir_d   = DirUp;
              wrap_d  = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ps_q    <= '0;
      dir_q   <= DirUp;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.at_max  = (count_q == bus.limit);
  assign bus.at_zero = (count_q == '0);

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench: PRESCALE=1 and PRESCALE=3 counters share stimulus and are
// compared every cycle against a behavioural model.
module tb_mode_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] limit;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  mode_counter_if #(.WIDTH(4)) if0 ();
  mode_counter_if #(.WIDTH(4)) if1 ();

  assign if0.en = en;  assign if0.load = load;  assign if0.load_val = load_val;
  assign if0.limit = limit;  assign if0.mode = mode;
  assign if1.en = en;  assign if1.load = load;  assign if1.load_val = load_val;
  assign if1.limit = limit;  assign if1.mode = mode;

  mode_counter #(.WIDTH(4), .PRESCALE(1)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  mode_counter #(.WIDTH(4), .PRESCALE(3)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  // Rising edges at 4, 14, 24, ... keep the timed reset events off the clock edge.
  initial begin
    clk = 1'b0;
    #4 clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Reference state per instance: count, prescale phase, direction (1=up), wrap pulse.
  int m_cnt[2];
  int m_ps[2];
  int m_dir[2];
  int m_wrap[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_ps[i] = 0; m_dir[i] = 1; m_wrap[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input int p);
    int c, lim;
    c   = m_cnt[i];
    lim = int'(limit);
    m_wrap[i] = 0;
    if (load) begin
      c = (int'(load_val) > lim) ? lim : int'(load_val);
      m_ps[i] = 0;
    end else if (en) begin
      if (m_ps[i] < p - 1) begin
        m_ps[i]++;
      end else begin
        m_ps[i] = 0;
        case (mode)
          2'd0: begin
            if (c >= lim) begin c = 0; m_wrap[i] = 1; end
            else c = c + 1;
          end
          2'd1: begin
            if (c == 0) begin c = lim; m_wrap[i] = 1; end
            else c = c - 1;
          end
          2'd2: c = (c >= lim) ? lim : c + 1;
          default: begin
            if (lim == 0) c = 0;
            else if (m_dir[i] == 1 && c < lim) c = c + 1;
            else if (m_dir[i] == 1) begin c = lim - 1; m_dir[i] = 0; m_wrap[i] = 1; end
            else if (c > 0) c = c - 1;
            else begin c = 1; m_dir[i] = 1; m_wrap[i] = 1; end
          end
        endcase
      end
    end
    m_cnt[i] = c;
  endtask

  task automatic check_inst(input int i);
    logic [3:0] c;
    logic       w, am, az;
    if (i == 0) begin c = if0.count; w = if0.wrap; am = if0.at_max; az = if0.at_zero; end
    else        begin c = if1.count; w = if1.wrap; am = if1.at_max; az = if1.at_zero; end
    check_eq($sformatf("u%0d_count", i), 32'(c), 32'(m_cnt[i]));
    check_eq($sformatf("u%0d_wrap", i), 32'(w), 32'(m_wrap[i]));
    check_eq($sformatf("u%0d_at_max", i), 32'(am), 32'(m_cnt[i] == int'(limit)));
    check_eq($sformatf("u%0d_at_zero", i), 32'(az), 32'(m_cnt[i] == 0));
  endtask

  task automatic check_all();
    check_inst(0);
    check_inst(1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      model_edge(0, 1);
      model_edge(1, 3);
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    reset = 1'b0;
  endtask

  int exp031[7] = '{5, 4, 3, 2, 1, 0, 5};
  int exp033[7] = '{1, 2, 3, 2, 1, 0, 1};

  initial begin
    reset = 1'b1; en = 1'b1; load = 1'b0; load_val = '0; limit = 4'd9; mode = 2'd0;
    model_reset();
    #1 check_all();
    #1 reset = 1'b0;

    // Timed async reset: assert at 12 for 33 ns, then again 25 ns after release.
    tick();
    check_eq("r035_run", 32'(if0.count), 32'd1);
    #7 reset = 1'b1;
    model_reset();
    #1 check_eq("r035_async1", 32'(if0.count), 32'd0);
    check_all();
    #31 check_all();
    #1 reset = 1'b0;
    tick();
    check_eq("r035_resume", 32'(if0.count), 32'd1);
    tick();
    #5 reset = 1'b1;
    model_reset();
    #1 check_eq("r035_async2", 32'(if0.count), 32'd0);
    check_all();
    #1 reset = 1'b0;

    // Up-wrap over 0..9.
    mode = 2'd0; limit = 4'd9; en = 1'b1;
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      tick();
      check_eq("r030_seq", 32'(if0.count), 32'(k % 10));
    end

    // Down-wrap over 0..5.
    mode = 2'd1; limit = 4'd5;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      tick();
      check_eq("r031_seq", 32'(if0.count), 32'(exp031[k]));
    end

    // Ping-pong over 0..3.
    mode = 2'd3; limit = 4'd3;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      tick();
      check_eq("r033_seq", 32'(if0.count), 32'(exp033[k]));
    end

    // Saturate at 15.
    mode = 2'd2; limit = 4'd15;
    do_reset();
    repeat (20) tick();
    check_eq("r032_hold", 32'(if0.count), 32'd15);
    check_eq("r032_at_max", 32'(if0.at_max), 32'd1);

    // Load clamps to limit and clears the prescaler.
    mode = 2'd0; limit = 4'd9; load = 1'b1; load_val = 4'd12; en = 1'b1;
    tick();
    check_eq("r034_load0", 32'(if0.count), 32'd9);
    check_eq("r034_load1", 32'(if1.count), 32'd9);
    load = 1'b0;
    tick();
    tick();
    check_eq("r034_ps_hold", 32'(if1.count), 32'd9);
    tick();
    check_eq("r034_ps_step", 32'(if1.count), 32'd0);
    en = 1'b0;
    repeat (4) tick();
    check_eq("r034_en_gap", 32'(if1.count), 32'd0);
    en = 1'b1;

    // Randomized run.
    for (int n = 0; n < 3000; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)  limit = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 255) == 0) do_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and limit width in bits (>=2).
REQ-002 Parameter PRESCALE, default 1, enabled cycles per count step (>=1).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; gates prescaler and steps.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_val  input  WIDTH  value loaded when load=1.
REQ-008 limit  input  WIDTH  upper bound of count range 0..limit, sampled every cycle.
REQ-009 mode  input  2  00 up-wrap, 01 down-wrap, 10 up-saturate, 11 ping-pong.
REQ-010 count  output  WIDTH  registered counter value.
REQ-011 wrap  output  1  registered one-cycle pulse after a wrap or ping-pong reversal.
REQ-012 at_max  output  1  combinational, high when count==limit.
REQ-013 at_zero  output  1  combinational, high when count==0.

Function
REQ-014 Prescaler counts 0..PRESCALE-1 on cycles with en=1 and holds when en=0; a "step" occurs on a cycle with en=1 and prescaler==PRESCALE-1, then the prescaler returns to 0; PRESCALE=1 steps on every enabled cycle.
REQ-015 Priority per edge: reset > load > step > hold.
REQ-016 load=1: count <= min(load_val, limit); prescaler <= 0; direction flag unchanged; wrap <= 0; en ignored that cycle.
REQ-017 Up-wrap step: count<limit -> count+1; count>=limit -> 0 with wrap=1 next cycle.
REQ-018 Down-wrap step: count>0 -> count-1; count==0 -> limit with wrap=1 next cycle.
REQ-019 Up-saturate step: count<limit -> count+1; count>=limit -> limit, no wrap pulse.
REQ-020 Ping-pong uses internal direction flag dir (1=up): dir up and count<limit -> count+1; dir up and count>=limit -> count<=limit-1 (limit>0), dir<=down, wrap=1; dir down and count>0 -> count-1; dir down and count==0 -> count<=1 (limit>0), dir<=up, wrap=1.
REQ-021 Ping-pong with limit==0: count stays 0, dir unchanged, no wrap pulse.
REQ-022 Up-wrap with limit==0: count stays 0 and wrap pulses after every step; down-wrap with limit==0 behaves identically.
REQ-023 Limit lowered below count: handled at next step per REQ-017..020 (up-wrap -> 0 with pulse, saturate -> limit, down-wrap decrements normally, ping-pong dir up -> limit-1 with reversal, ping-pong dir down -> count-1); no change without a step.
REQ-024 Mode change takes effect on the next step; dir retained across mode changes and only consulted in ping-pong.
REQ-025 wrap is high for exactly one cycle following the causing step and low on all other cycles, including hold and load cycles.
REQ-026 All arithmetic is WIDTH-bit unsigned; no intermediate value exceeds limit or goes below 0.

Reset
REQ-027 reset=1 asynchronously forces count=0, prescaler=0, dir=up, wrap=0 without waiting for a clock edge.
REQ-028 While reset=1 all inputs are ignored; first step or load is possible on the first rising edge after reset deasserts.
REQ-029 Reset asserted mid-count (any mode, any prescaler phase) restarts from the REQ-027 state.

Verification
REQ-030 WIDTH=4, mode=00, limit=9, en=1 -> count 0..9,0,1; wrap high only in the cycle after 9->0; at_max high while count=9.
REQ-031 mode=01, limit=5, from reset -> count 5,4,3,2,1,0,5; wrap high after 0->5 steps only.
REQ-032 mode=10, limit=15, run 20 steps -> count holds 15, at_max=1, wrap never asserts.
REQ-033 mode=11, limit=3 -> count 0,1,2,3,2,1,0,1; wrap high after 3->2 and 0->1 steps.
REQ-034 load=1, en=1, load_val=12, limit=9 -> count=9 next edge, prescaler cleared; PRESCALE=3 instance with en=1 -> count advances every 3rd cycle, holds during en=0 gaps.
REQ-035 Assert reset at 12 ns for 33 ns, release, reassert 25 ns later mid-count -> count=0 immediately on each assertion (before next clk edge), counting resumes from 0 after release.
